// File: rtl/hs_pkg.sv
// Shared constants for the valid/ready register slice family.
package hs_pkg;

  // Timing-mode encodings for hs_reg_slice.
  localparam int unsigned HS_BYPASS = 0;
  localparam int unsigned HS_FWD    = 1;
  localparam int unsigned HS_BWD    = 2;
  localparam int unsigned HS_FULL   = 3;

  // Occupancy count type: 0..2 beats.
  typedef logic [1:0] hs_occ_t;

endpackage

// File: rtl/hs_data_reg.sv
// Payload register with load enable and synchronous clear.
module hs_data_reg #(
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hs_reg_slice.sv
// Valid/ready register slice with selectable timing mode.
module hs_reg_slice
  import hs_pkg::*;
#(
  parameter int unsigned DATA_W       = 3,
  parameter int unsigned MODE         = HS_FULL,
  parameter int unsigned ZERO_INVALID = 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_ready,
  output hs_occ_t           occupancy
);

  logic              dn_valid_raw;
  logic [DATA_W-1:0] dn_data_raw;

  if (MODE == HS_BYPASS) begin : g_bypass
    logic unused_ok;
    assign unused_ok    = ^{sys_clk, rst, flush};
    assign dn_valid_raw = up_valid;
    assign dn_data_raw  = up_data;
    assign up_ready     = dn_ready;
    assign occupancy    = '0;

  end else if (MODE == HS_FWD) begin : g_fwd
    logic              main_v;
    logic [DATA_W-1:0] main_q;
    logic              open;
    logic              up_xfer;
    logic              dn_xfer;

    // Both handshakes are closed during rst and flush so nothing can move.
    assign open         = !rst && !flush;
    assign up_ready     = open && (dn_ready || !main_v);
    assign dn_valid_raw = open && main_v;
    assign dn_data_raw  = main_q;
    assign up_xfer      = up_valid && up_ready;
    assign dn_xfer      = dn_valid_raw && dn_ready;
    assign occupancy    = {1'b0, main_v};

    always_ff @(posedge sys_clk) begin
      if (rst || flush) begin
        main_v <= 1'b0;
      end else if (up_xfer) begin
        main_v <= 1'b1;
      end else if (dn_xfer) begin
        main_v <= 1'b0;
      end
    end

    hs_data_reg #(.DATA_W(DATA_W)) u_main (
      .clk (sys_clk),
      .clr (rst),
      .en  (up_xfer),
      .d   (up_data),
      .q   (main_q)
    );

  end else if (MODE == HS_BWD) begin : g_bwd
    logic              skid_v;
    logic [DATA_W-1:0] skid_q;
    logic              open;
    logic              up_xfer;
    logic              dn_xfer;
    logic              capture;

    assign open         = !rst && !flush;
    assign up_ready     = open && !skid_v;
    assign dn_valid_raw = open && (skid_v || up_valid);
    assign dn_data_raw  = skid_v ? skid_q : up_data;
    assign up_xfer      = up_valid && up_ready;
    assign dn_xfer      = dn_valid_raw && dn_ready;
    // An accepted beat that is not taken straight through parks in skid.
    assign capture      = up_xfer && !dn_xfer;
    assign occupancy    = {1'b0, skid_v};

    always_ff @(posedge sys_clk) begin
      if (rst || flush) begin
        skid_v <= 1'b0;
      end else if (capture) begin
        skid_v <= 1'b1;
      end else if (skid_v && dn_xfer) begin
        skid_v <= 1'b0;
      end
    end

    hs_data_reg #(.DATA_W(DATA_W)) u_skid (
      .clk (sys_clk),
      .clr (rst),
      .en  (capture),
      .d   (up_data),
      .q   (skid_q)
    );

  end else if (MODE == HS_FULL) begin : g_full
    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] main_d;
    logic              open;
    logic              up_xfer;
    logic              dn_xfer;
    logic              main_from_skid;
    logic              main_from_up;
    logic              main_en;
    logic              skid_load;

    assign open         = !rst && !flush;
    assign up_ready     = open && !skid_v;
    assign dn_valid_raw = open && main_v;
    assign dn_data_raw  = main_q;
    assign up_xfer      = up_valid && up_ready;
    assign dn_xfer      = dn_valid_raw && dn_ready;

    // skid_v blocks up_ready, so a skid refill and an upstream load never coincide.
    assign main_from_skid = dn_xfer && skid_v;
    assign main_from_up   = up_xfer && (!main_v || dn_xfer);
    assign skid_load      = up_xfer && main_v && !dn_xfer;
    assign main_en        = main_from_skid || main_from_up;
    assign main_d         = main_from_skid ? skid_q : up_data;
    assign occupancy      = {1'b0, main_v} + {1'b0, skid_v};

    always_ff @(posedge sys_clk) begin
      if (rst || flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else begin
        if (main_en) begin
          main_v <= 1'b1;
        end else if (dn_xfer) begin
          main_v <= 1'b0;
        end
        if (skid_load) begin
          skid_v <= 1'b1;
        end else if (main_from_skid) begin
          skid_v <= 1'b0;
        end
      end
    end

    hs_data_reg #(.DATA_W(DATA_W)) u_main (
      .clk (sys_clk),
      .clr (rst),
      .en  (main_en),
      .d   (main_d),
      .q   (main_q)
    );

    hs_data_reg #(.DATA_W(DATA_W)) u_skid (
      .clk (sys_clk),
      .clr (rst),
      .en  (skid_load),
      .d   (up_data),
      .q   (skid_q)
    );

  end else begin : g_bad_mode
    $error("hs_reg_slice: MODE %0d is not supported (0..3)", MODE);
  end

  assign dn_valid = dn_valid_raw;
  assign dn_data  = ((ZERO_INVALID != 0) && !dn_valid_raw) ? '0 : dn_data_raw;

endmodule

// File: tb/tb_hs_reg_slice.sv
module tb_hs_reg_slice;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       flush [4];
  logic       uv    [4];
  logic [2:0] ud    [4];
  logic       ur    [4];
  logic       dv    [4];
  logic [2:0] dd    [4];
  logic       dr    [4];
  logic [1:0] occ   [4];

  int n_chk  = 0;
  int n_fail = 0;

  // Per-DUT scoreboard ring buffers.
  logic [2:0] fifo [4][16];
  int         wp   [4];
  int         rp   [4];
  logic       pend [4];
  logic       hold [4];
  logic [2:0] hdd  [4];

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    hs_reg_slice #(
      .DATA_W       (3),
      .MODE         (g),
      .ZERO_INVALID (1)
    ) u_dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .flush     (flush[g]),
      .up_valid  (uv[g]),
      .up_data   (ud[g]),
      .up_ready  (ur[g]),
      .dn_valid  (dv[g]),
      .dn_data   (dd[g]),
      .dn_ready  (dr[g]),
      .occupancy (occ[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flush[i] = 1'b0; uv[i] = 1'b0; ud[i] = '0; dr[i] = 1'b0;
      wp[i] = 0; rp[i] = 0; pend[i] = 1'b0; hold[i] = 1'b0; hdd[i] = '0;
    end

    // Reset behaviour
    #2;
    chk("rst_ur1", ur[1], 0);
    chk("rst_ur2", ur[2], 0);
    chk("rst_ur3", ur[3], 0);
    tick(); tick();
    for (int i = 1; i < 4; i++) begin
      chk("rst_occ", occ[i], 0);
      chk("rst_dv", dv[i], 0);
      chk("rst_dd", dd[i], 0);
    end
    rst = 1'b0;
    #1;
    for (int i = 1; i < 4; i++) chk("rel_ur", ur[i], 1);

    // MODE 1 streaming 1..4
    dr[1] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      uv[1] = 1'b1; ud[1] = 3'(k);
      #1;
      chk("m1_ur", ur[1], 1);
      if (k > 1) begin
        chk("m1_dv", dv[1], 1);
        chk("m1_dd", dd[1], k - 1);
        chk("m1_occ", occ[1], 1);
      end
      tick();
    end
    uv[1] = 1'b0;
    #1;
    chk("m1_dv_last", dv[1], 1);
    chk("m1_dd_last", dd[1], 4);
    tick();
    chk("m1_dv_idle", dv[1], 0);
    chk("m1_dd_idle", dd[1], 0);
    chk("m1_occ_idle", occ[1], 0);
    dr[1] = 1'b0;

    // MODE 3 fill while stalled, then drain in order
    uv[3] = 1'b1; ud[3] = 3'd5;
    #1;
    chk("m3_ur_a", ur[3], 1);
    tick();
    ud[3] = 3'd6;
    #1;
    chk("m3_ur_b", ur[3], 1);
    chk("m3_dd_b", dd[3], 5);
    chk("m3_occ_b", occ[3], 1);
    tick();
    ud[3] = 3'd7;
    #1;
    chk("m3_ur_full", ur[3], 0);
    chk("m3_occ_full", occ[3], 2);
    chk("m3_dd_full", dd[3], 5);
    tick();
    chk("m3_ur_hold", ur[3], 0);
    chk("m3_dv_hold", dv[3], 1);
    chk("m3_dd_hold", dd[3], 5);
    dr[3] = 1'b1;
    #1;
    chk("m3_out5", dd[3], 5);
    tick();
    chk("m3_out6", dd[3], 6);
    chk("m3_ur_reopen", ur[3], 1);
    chk("m3_occ_one", occ[3], 1);
    tick();
    uv[3] = 1'b0;
    #1;
    chk("m3_out7", dd[3], 7);
    chk("m3_dv7", dv[3], 1);
    chk("m3_occ7", occ[3], 1);
    tick();
    chk("m3_dv_empty", dv[3], 0);
    chk("m3_occ_empty", occ[3], 0);
    dr[3] = 1'b0;

    // MODE 2 skid capture and drain
    uv[2] = 1'b1; ud[2] = 3'd3;
    #1;
    chk("m2_dv_comb", dv[2], 1);
    chk("m2_dd_comb", dd[2], 3);
    chk("m2_ur_a", ur[2], 1);
    tick();
    uv[2] = 1'b0;
    #1;
    chk("m2_ur_skid", ur[2], 0);
    chk("m2_occ_skid", occ[2], 1);
    chk("m2_dv_skid", dv[2], 1);
    chk("m2_dd_skid", dd[2], 3);
    dr[2] = 1'b1;
    tick();
    chk("m2_ur_back", ur[2], 1);
    chk("m2_dv_done", dv[2], 0);
    chk("m2_dd_done", dd[2], 0);
    chk("m2_occ_done", occ[2], 0);
    dr[2] = 1'b0;

    // MODE 3 flush with two beats held
    uv[3] = 1'b1; ud[3] = 3'd2;
    tick();
    ud[3] = 3'd4;
    tick();
    uv[3] = 1'b0;
    #1;
    chk("fl_occ_pre", occ[3], 2);
    flush[3] = 1'b1;
    #1;
    chk("fl_ur", ur[3], 0);
    chk("fl_dv", dv[3], 0);
    chk("fl_dd", dd[3], 0);
    tick();
    flush[3] = 1'b0;
    #1;
    chk("fl_occ_post", occ[3], 0);
    chk("fl_dv_post", dv[3], 0);
    chk("fl_dd_post", dd[3], 0);
    chk("fl_ur_post", ur[3], 1);
    uv[3] = 1'b1; ud[3] = 3'd1; dr[3] = 1'b1;
    tick();
    uv[3] = 1'b0;
    #1;
    chk("fl_next_dv", dv[3], 1);
    chk("fl_next_dd", dd[3], 1);
    chk("fl_next_occ", occ[3], 1);
    tick();
    chk("fl_next_gone", dv[3], 0);
    dr[3] = 1'b0;

    // MODE 1 reset mid-stream
    uv[1] = 1'b1; ud[1] = 3'd6;
    tick();
    uv[1] = 1'b0;
    #1;
    chk("mr_dv_pre", dv[1], 1);
    chk("mr_dd_pre", dd[1], 6);
    rst = 1'b1;
    #1;
    chk("mr_ur_rst", ur[1], 0);
    tick();
    chk("mr_dv", dv[1], 0);
    chk("mr_dd", dd[1], 0);
    chk("mr_occ", occ[1], 0);
    chk("mr_ur_still", ur[1], 0);
    rst = 1'b0;
    #1;
    chk("mr_ur_rel", ur[1], 1);

    // MODE 0 bypass
    uv[0] = 1'b1; ud[0] = 3'd5;
    #1;
    chk("m0_dv", dv[0], 1);
    chk("m0_dd", dd[0], 5);
    chk("m0_ur_lo", ur[0], 0);
    chk("m0_occ", occ[0], 0);
    dr[0] = 1'b1;
    flush[0] = 1'b1;
    #1;
    chk("m0_ur_hi", ur[0], 1);
    chk("m0_flush_ign", dv[0], 1);
    uv[0] = 1'b0;
    #1;
    chk("m0_dd_zero", dd[0], 0);
    flush[0] = 1'b0; dr[0] = 1'b0;
    tick();

    // Random traffic on all four modes against per-DUT scoreboards
    for (int c = 0; c < 3040; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          uv[i] = (c < 3000) && ($urandom_range(0, 9) < 6);
          ud[i] = 3'($urandom_range(0, 7));
        end
        dr[i] = (c >= 3000) || ($urandom_range(0, 9) < 6);
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hold[i]) begin
          chk("rnd_stable_v", dv[i], 1);
          chk("rnd_stable_d", dd[i], hdd[i]);
        end
        if (uv[i] && ur[i]) begin
          fifo[i][wp[i] % 16] = ud[i];
          wp[i]++;
        end
        if (dv[i] && dr[i]) begin
          chk("rnd_nonempty", (wp[i] != rp[i]), 1);
          if (wp[i] != rp[i]) begin
            chk("rnd_data", dd[i], fifo[i][rp[i] % 16]);
            rp[i]++;
          end
        end
        hold[i] = dv[i] && !dr[i];
        hdd[i]  = dd[i];
        pend[i] = uv[i] && !ur[i];
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("rnd_drained", wp[i] - rp[i], 0);
      chk("rnd_occ_end", occ[i], 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
